// File: rtl/fp_pack_round.sv
// -----------------------------------------------------------------------------
// fp_pack_round
//
// Final stage shared by the FP add/mul/div/sqrt pipelines. Takes a normalised
// sign / biased exponent / extended mantissa (with guard, round and sticky
// bits), applies RISC-V rounding, handles overflow and underflow, and packs
// the IEEE-754 word.
//
// Pipeline: two register stages behind a valid/ready handshake. One word per
// cycle throughput, order preserved, no skid buffer (in_ready depends
// combinationally on out_ready).
//   S1 : rounding (round-up decision, mantissa increment, exponent carry)
//   S2 : range check, class override, packing; drives out_* directly
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   in_valid    input word valid
//   in_ready    stage can accept an input word
//   in_sign     result sign
//   in_exp      biased exponent, EXP_W+2 bit two's complement
//   in_mant     {hidden, fraction[MAN_W-1:0], G, R, S}
//   in_class    00 normal, 01 zero, 10 infinity, 11 NaN
//   in_rm       000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   out_valid   result valid
//   out_ready   consumer accepts result
//   out_result  packed {sign, exponent, fraction}
//   out_flags   {OF, UF, NX}
//
// Build option
//   FP_PACK_FLAGS_EN  when defined, out_flags is computed and registered
//                     alongside out_result. When undefined, out_flags is
//                     tied to zero and no flag state exists. Result values
//                     are identical in both builds.
// -----------------------------------------------------------------------------
module fp_pack_round #(
    parameter  int EXP_W  = 8,
    parameter  int MAN_W  = 23,
    localparam int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W+1:0]  in_exp,
    input  logic [MAN_W+3:0]  in_mant,
    input  logic [1:0]        in_class,
    input  logic [2:0]        in_rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_flags
);

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } cls_e;

    // Smallest biased exponent that no longer fits a finite number.
    localparam logic [EXP_W+1:0] EXP_OVF = {2'b00, {EXP_W{1'b1}}};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ------------------------------------------------------------------
    // S1: rounding
    // ------------------------------------------------------------------
    rm_e              rm_eff;
    logic             lsb;
    logic             g_bit;
    logic             r_bit;
    logic             s_bit;
    logic             inexact;
    logic             round_up;
    logic [MAN_W+1:0] m_rnd;
    logic             carry;
    logic [MAN_W-1:0] frac_rnd;
    logic [EXP_W+1:0] exp_adj;

    // The rounded hidden bit carries no information once the carry is known.
    logic unused_hidden;
    assign unused_hidden = m_rnd[MAN_W];

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        rm_eff = RM_RNE;
        case (in_rm)
            3'd1:    rm_eff = RM_RTZ;
            3'd2:    rm_eff = RM_RDN;
            3'd3:    rm_eff = RM_RUP;
            3'd4:    rm_eff = RM_RMM;
            default: rm_eff = RM_RNE;
        endcase

        lsb     = in_mant[3];
        g_bit   = in_mant[2];
        r_bit   = in_mant[1];
        s_bit   = in_mant[0];
        inexact = g_bit | r_bit | s_bit;

        round_up = 1'b0;
        case (rm_eff)
            RM_RNE:  round_up = g_bit & (r_bit | s_bit | lsb);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = in_sign & inexact;
            RM_RUP:  round_up = !in_sign & inexact;
            RM_RMM:  round_up = g_bit;
            default: round_up = 1'b0;
        endcase

        // {hidden, fraction} + round_up; a carry out means the mantissa
        // wrapped to 1.000..., so bump the exponent and clear the fraction.
        m_rnd    = {1'b0, in_mant[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};
        carry    = m_rnd[MAN_W+1];
        frac_rnd = carry ? '0 : m_rnd[MAN_W-1:0];
        exp_adj  = in_exp + {{(EXP_W+1){1'b0}}, carry};
    end

    logic             s1_sign;
    logic [EXP_W+1:0] s1_exp;
    logic [MAN_W-1:0] s1_frac;
    rm_e              s1_rm;
    cls_e             s1_class;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: payload registers are not reset; s1_valid qualifies them, and
    // leaving them free keeps reset fan-out to the control bits only.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_sign  <= in_sign;
            s1_exp   <= exp_adj;
            s1_frac  <= frac_rnd;
            s1_rm    <= rm_eff;
            s1_class <= cls_e'(in_class);
        end
    end

    // ------------------------------------------------------------------
    // S2: range check, class override, pack
    // ------------------------------------------------------------------
    logic              overflow;
    logic              underflow;
    logic              to_inf;
    logic [DATA_W-1:0] res_d;

    always_comb begin
        // Exponent is two's complement: a set top bit means negative.
        overflow  = !s1_exp[EXP_W+1] && (s1_exp >= EXP_OVF);
        underflow = s1_exp[EXP_W+1] || (s1_exp == '0);

        // Overflow saturates to infinity only when rounding points away
        // from zero; otherwise it clamps to the largest finite value.
        to_inf = (s1_rm == RM_RNE) || (s1_rm == RM_RMM) ||
                 ((s1_rm == RM_RUP) && !s1_sign) ||
                 ((s1_rm == RM_RDN) &&  s1_sign);

        res_d = {s1_sign, s1_exp[EXP_W-1:0], s1_frac};
        case (s1_class)
            CLS_ZERO: res_d = {s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            CLS_INF:  res_d = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_NAN:  res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            default: begin
                if (overflow) begin
                    if (to_inf) begin
                        res_d = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else begin
                        res_d = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                    end
                end else if (underflow) begin
                    // No subnormal output: flush to signed zero.
                    res_d = {s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_d;
            end
        end
    end

`ifdef FP_PACK_FLAGS_EN
    // Inexact travels with the word through S1 only when flags exist.
    logic       s1_inexact;
    logic [2:0] flags_d;

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_inexact <= inexact;
        end
    end

    always_comb begin
        flags_d = 3'b000;
        if (s1_class == CLS_NORMAL) begin
            if (overflow) begin
                flags_d = 3'b101;
            end else if (underflow) begin
                flags_d = 3'b011;
            end else begin
                flags_d = {2'b00, s1_inexact};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_flags <= 3'b000;
        end else if (s2_adv && s1_valid) begin
            out_flags <= flags_d;
        end
    end
`else
    assign out_flags = 3'b000;
`endif

endmodule

// File: tb/tb_fp_pack_round.sv
// -----------------------------------------------------------------------------
// tb_fp_pack_round
//
// Directed bench for fp_pack_round (EXP_W=8, MAN_W=23). Each vector carries a
// hand-computed binary32 result and flags; flag expectations collapse to zero
// when FP_PACK_FLAGS_EN is not defined. Also covers backpressure, ordering,
// and reset with words in flight.
// -----------------------------------------------------------------------------
module tb_fp_pack_round;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [26:0] in_mant;
    logic [1:0]  in_class;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int n_vec = 0;
    int n_bad = 0;

    fp_pack_round #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_class   (in_class),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] fx(input logic [2:0] f);
`ifdef FP_PACK_FLAGS_EN
        return f;
`else
        return 3'b000;
`endif
    endfunction

    // Stream word i: exact normal value with exponent 127+i and fraction i.
    function automatic logic [31:0] word_res(input int i);
        logic [7:0]  e;
        logic [22:0] f;
        e = 8'(127 + i);
        f = 23'(i);
        return {1'b0, e, f};
    endfunction

    task automatic drive(input logic s, input logic [9:0] e, input logic [22:0] f,
                         input logic [2:0] grs, input logic [1:0] cls, input logic [2:0] rm);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = {1'b1, f, grs};
        in_class = cls;
        in_rm    = rm;
    endtask

    task automatic drive_word(input int i);
        drive(1'b0, 10'(127 + i), 23'(i), 3'b000, 2'b00, 3'd0);
    endtask

    // One vector through an otherwise idle pipe with out_ready high; also
    // checks the two-cycle latency.
    task automatic run_vec(input string tag, input logic s, input logic [9:0] e,
                           input logic [22:0] f, input logic [2:0] grs,
                           input logic [1:0] cls, input logic [2:0] rm,
                           input logic [31:0] want_res, input logic [2:0] want_flg);
        @(negedge clk);
        out_ready = 1'b1;
        drive(s, e, f, grs, cls, rm);
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, out_result, want_res);
        check({tag, "_flags"}, 32'(out_flags), 32'(fx(want_flg)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int rcv;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_class  = '0;
        in_rm     = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ---------------- directed rounding / range / class vectors ----------
        run_vec("rne_tie_even", 1'b0, 10'd127, 23'h000000, 3'b100, 2'b00, 3'd0, 32'h3F800000, 3'b001);
        run_vec("rne_tie_odd",  1'b0, 10'd127, 23'h000001, 3'b100, 2'b00, 3'd0, 32'h3F800002, 3'b001);
        run_vec("rne_carry",    1'b0, 10'd127, 23'h7FFFFF, 3'b100, 2'b00, 3'd0, 32'h40000000, 3'b001);
        run_vec("of_rne",       1'b0, 10'd254, 23'h7FFFFF, 3'b110, 2'b00, 3'd0, 32'h7F800000, 3'b101);
        run_vec("of_rtz",       1'b0, 10'd254, 23'h7FFFFF, 3'b110, 2'b00, 3'd1, 32'h7F7FFFFF, 3'b001);
        run_vec("of_rup_neg",   1'b1, 10'd254, 23'h7FFFFF, 3'b110, 2'b00, 3'd3, 32'hFF7FFFFF, 3'b001);
        run_vec("of_exp255_rdn",1'b0, 10'd255, 23'h000000, 3'b000, 2'b00, 3'd2, 32'h7F7FFFFF, 3'b101);
        run_vec("uf_neg_zero",  1'b1, 10'd0,   23'h000123, 3'b000, 2'b00, 3'd0, 32'h80000000, 3'b011);
        run_vec("uf_neg_exp",   1'b0, 10'h3FB, 23'h000000, 3'b000, 2'b00, 3'd0, 32'h00000000, 3'b011);
        run_vec("cls_nan",      1'b1, 10'd5,   23'h000011, 3'b111, 2'b11, 3'd0, 32'h7FC00000, 3'b000);
        run_vec("cls_inf_neg",  1'b1, 10'd5,   23'h000000, 3'b111, 2'b10, 3'd0, 32'hFF800000, 3'b000);
        run_vec("cls_zero_neg", 1'b1, 10'd5,   23'h000000, 3'b111, 2'b01, 3'd0, 32'h80000000, 3'b000);
        run_vec("rdn_neg",      1'b1, 10'd127, 23'h000000, 3'b001, 2'b00, 3'd2, 32'hBF800001, 3'b001);
        run_vec("rmm_tie",      1'b0, 10'd127, 23'h000000, 3'b100, 2'b00, 3'd4, 32'h3F800001, 3'b001);
        run_vec("rm7_is_rne",   1'b0, 10'd127, 23'h000000, 3'b100, 2'b00, 3'd7, 32'h3F800000, 3'b001);
        run_vec("exact",        1'b0, 10'd127, 23'h000000, 3'b000, 2'b00, 3'd0, 32'h3F800000, 3'b000);

        // drain
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- backpressure: stall with out_ready low ------------
        acc = 0;
        rcv = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            drive_word(acc);
            #1;
            if (acc >= 2 && out_valid) check("bp_hold", out_result, word_res(0));
            if (in_ready) acc++;
        end
        check("bp_accepts", 32'(acc), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);

        // release and collect all four words in order
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (acc < 4) drive_word(acc);
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                check($sformatf("bp_word%0d", rcv), out_result, word_res(rcv));
                rcv++;
            end
            if (in_valid && in_ready) acc++;
            if (rcv == 4) break;
        end
        check("bp_received", 32'(rcv), 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // ---------------- reset with two words in flight --------------------
        @(negedge clk);
        drive_word(4);
        @(negedge clk);
        drive_word(5);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_result", out_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_word(6);
        @(posedge clk);
        #1;
        check("post_rst_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_res", out_result, word_res(6));
        @(posedge clk);
        #1;
        check("post_rst_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
